alu_instr_controller: RTL
=========================

# alu_instr_controller

Multi-cycle control FSM that drives the ALU datapath: it latches a 16-bit instruction, decodes it, and sequences register-file reads, operand loads, ALU execution and write-back. It is the initiator to the ALU/datapath responder. It produces `ALUop`, the operand-select and load strobes, and register indices. Instructions are accepted through a start/wait handshake from the surrounding CPU top level.

## Interface
Parameters:
- none

Ports (`clk` and `reset_n` first):
- `clk`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `s`  in  1  start; sampled only in WAIT
- `in_instr`  in  16  instruction, captured into IR when a start is accepted
- `w`  out  1  1 exactly while in WAIT (ready for a new instruction)
- `err`  out  1  sticky illegal-instruction flag (see Configuration)
- `readnum`  out  3  register-file read index
- `writenum`  out  3  register-file write index
- `write`  out  1  register-file write enable
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load strobes for A, B, C and status registers
- `asel`  out  1  1 = ALU A input forced to 16'b0
- `bsel`  out  1  0 = shifted B (`bsel` is held at 0 in this version)
- `vsel`  out  1  write-back source: 0 = C, 1 = `sximm8`
- `ALUop`  out  2  ALU operation (00 add, 01 sub, 10 and, 11 not B)
- `shift`  out  2  shifter control, equal to IR[4:3]
- `sximm8`  out  16  IR[7:0] sign-extended to 16 bits

## Operation
- IR fields:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
- Accepting a start:
  - A start is accepted on an edge where the state is WAIT and `s`=1.
  - On that edge IR <= `in_instr` and the state goes to DECODE.
  - `s` has no effect in any other state.
- Combinational outputs from IR: `ALUop` = (opcode==110) ? 00 : op. `shift` = sh. `sximm8` = {{8{IR[7]}}, IR[7:0]}.
- States are Moore-decoded. Every strobe not listed for a state is 0.
  - WAIT: `w`=1.
  - DECODE: no strobes.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - EXEC: `loadc`=1, except CMP, where `loads`=1 and `loadc`=0. `asel`=1 for MOV-reg only.
  - WRITE_REG: `write`=1, `vsel`=0, `writenum`=Rd.
  - WRITE_IMM: `write`=1, `vsel`=1, `writenum`=Rn.
- Transitions out of DECODE:
  - 110/10 (MOV Rn,#imm8): WRITE_IMM, then WAIT.
  - 110/00 (MOV Rd,Rm{sh}): GET_B, EXEC, WRITE_REG, then WAIT.
  - 101/00 ADD and 101/10 AND: GET_A, GET_B, EXEC, WRITE_REG, then WAIT.
  - 101/01 CMP: GET_A, GET_B, EXEC, then WAIT (no register write).
  - 101/11 MVN: GET_B, EXEC, WRITE_REG, then WAIT.
  - Any other encoding is illegal: DECODE goes directly to WAIT with no strobes.
- `readnum` and `writenum` are 0 in states that do not use them.

## Timing
- Reset: on an edge with `reset_n`=0, the state becomes WAIT and IR becomes 0. This gives `w`=1, `err`=0 and all strobes 0, regardless of the current state.
  - A reset during WRITE_REG or WRITE_IMM suppresses any further write; no partial sequence resumes.
- Latency is counted from the accepting edge to the edge at which the FSM re-enters WAIT:
  - MOV imm: 2 cycles
  - MOV reg and MVN: 4 cycles
  - CMP: 4 cycles
  - ADD and AND: 5 cycles
  - illegal: 1 cycle
- `s` held high continuously starts back-to-back instructions. Each new instruction is accepted on the edge after the one-cycle WAIT.
- `in_instr` is sampled only on the accepting edge; later changes have no effect.

## Configuration
- `ALU_CTRL_ILLEGAL_TRAP_EN` defined:
  - On an illegal DECODE, `err` is set.
  - `err` stays 1 until reset.
  - While `err`=1, the FSM stays in WAIT with `w`=1 and ignores `s`.
- Not defined:
  - `err` is tied to 0.
  - Illegal encodings behave as a one-cycle no-op and the next start is accepted normally.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles mid-ADD (in EXEC) -> after the edge, `w`=1, `write`=0, `err`=0; no WRITE_REG cycle follows.
- MOV imm: `in_instr`=16'hD1FF, `s`=1 -> WRITE_IMM 1 cycle after accept with `writenum`=1, `vsel`=1, `sximm8`=16'hFFFF; `w`=1 at accept+2.
- ADD: `in_instr`=16'hA140 (ADD R2,R1,R0) -> GET_A `readnum`=1, GET_B `readnum`=0, EXEC `loadc`=1 with `ALUop`=00, WRITE_REG `writenum`=2; `w` returns at accept+5.
- CMP: `in_instr`=16'hA900 -> EXEC with `loads`=1, `loadc`=0, `ALUop`=01; `write` stays 0 throughout; `w` returns at accept+4.
- MVN: `in_instr`=16'hB868 -> no GET_A cycle; GET_B `readnum`=0, `shift`=01, `ALUop`=11, WRITE_REG `writenum`=3.
- Illegal: `in_instr`=16'h0000 -> with the macro, `err`=1 and a following `s` pulse is ignored; without it, `err`=0 and `in_instr`=16'hD007 is then accepted normally.

Source files
------------

// File: rtl/alu_instr_controller.sv
// Multi-cycle control FSM for the ALU datapath: latches an instruction, decodes it and
// sequences operand reads, execution and write-back. Optional trap: ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_instr_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] in_instr,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    localparam int unsigned IW = 16;
    localparam int unsigned RW = 3;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WRITE_REG,
        ST_WRITE_IMM
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ir;
    logic            trap;
    logic            accept;

    // Instruction field and class decode from the latched IR
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [RW-1:0] rm;
    logic          is_mov_imm;
    logic          is_mov_reg;
    logic          is_two_op;
    logic          is_cmp;
    logic          is_mvn;

    assign opcode     = ir[15:13];
    assign op         = ir[12:11];
    assign rn         = ir[10:8];
    assign rd         = ir[7:5];
    assign rm         = ir[2:0];
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_two_op  = (opcode == 3'b101) && ((op == 2'b00) || (op == 2'b10));
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);

    assign ALUop  = (opcode == 3'b110) ? 2'b00 : op;
    assign shift  = ir[4:3];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign bsel   = 1'b0;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal;
    logic err_q;

    assign illegal = ~(is_mov_imm | is_mov_reg | is_two_op | is_cmp | is_mvn);

    // Sticky trap: once set, the FSM parks in WAIT until reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((state == ST_DECODE) && illegal) begin
            err_q <= 1'b1;
        end
    end

    assign trap = err_q;
`else
    assign trap = 1'b0;
`endif

    assign err    = trap;
    assign accept = (state == ST_WAIT) && s && !trap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_WAIT;
            ir    <= IW'(0);
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir <= in_instr;
            end
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = RW'(0);
        writenum  = RW'(0);
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        vsel      = 1'b0;
        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (accept) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mov_imm) begin
                    state_nxt = ST_WRITE_IMM;
                end else if (is_two_op || is_cmp) begin
                    state_nxt = ST_GET_A;
                end else if (is_mov_reg || is_mvn) begin
                    state_nxt = ST_GET_B;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = ST_GET_B;
            end
            ST_GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                loadc     = !is_cmp;
                loads     = is_cmp;
                asel      = is_mov_reg;
                state_nxt = is_cmp ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
                write     = 1'b1;
                writenum  = rd;
                state_nxt = ST_WAIT;
            end
            ST_WRITE_IMM: begin
                write     = 1'b1;
                vsel      = 1'b1;
                writenum  = rn;
                state_nxt = ST_WAIT;
            end
            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

endmodule
